// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC generation, one-cycle-latency imem interface,
// registered output with a one-entry skid buffer. Optional macro FETCH_MISALIGN_TRAP_EN.
module fetch_stage #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h0100_0000)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_o,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic [DWIDTH-1:0] imem_rdata_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              valid_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [AWIDTH-1:0] pc_o,
  output logic              misalign_o
);

  localparam logic [DWIDTH-1:0] NOP_INSN = DWIDTH'(32'h0000_0013);

  logic [AWIDTH-1:0] pc_reg, pc_next;
  logic              out_valid_reg, out_valid_next;
  logic [DWIDTH-1:0] out_insn_reg, out_insn_next;
  logic [AWIDTH-1:0] out_pc_reg, out_pc_next;
  logic              skid_valid_reg, skid_valid_next;
  logic [DWIDTH-1:0] skid_insn_reg, skid_insn_next;
  logic [AWIDTH-1:0] skid_pc_reg, skid_pc_next;
  logic              inflight_reg, inflight_next;
  logic [AWIDTH-1:0] inflight_pc_reg, inflight_pc_next;
  logic              halted_reg, halted_next;

  logic              consume;
  logic              out_free;
  logic              resp_valid;
  logic              req;
  logic [2:0]        occupancy;
  logic [AWIDTH-1:0] target_pc;
  logic              set_misalign;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target_pc    = redirect_pc_i;
  assign set_misalign = redirect_i & (redirect_pc_i[1:0] != 2'b00);
  assign misalign_o   = halted_reg;
`else
  // Without the trap, low target bits are simply ignored.
  assign target_pc    = {redirect_pc_i[AWIDTH-1:2], 2'b00};
  assign set_misalign = 1'b0;
  assign misalign_o   = 1'b0;
`endif

  assign consume    = out_valid_reg & ~stall_i;
  assign out_free   = ~out_valid_reg | ~stall_i;
  assign resp_valid = inflight_reg;
  assign occupancy  = 3'(out_valid_reg) + 3'(skid_valid_reg) + 3'(inflight_reg) - 3'(consume);
  assign req        = ~rst & ~redirect_i & ~halted_reg & (occupancy < 3'd2);

  assign imem_req_o  = req;
  assign imem_addr_o = pc_reg;
  assign valid_o     = out_valid_reg;
  assign insn_o      = out_insn_reg;
  assign pc_o        = out_pc_reg;

  always_comb begin
    pc_next          = pc_reg;
    out_valid_next   = out_valid_reg;
    out_insn_next    = out_insn_reg;
    out_pc_next      = out_pc_reg;
    skid_valid_next  = skid_valid_reg;
    skid_insn_next   = skid_insn_reg;
    skid_pc_next     = skid_pc_reg;
    inflight_next    = req;
    inflight_pc_next = pc_reg;
    halted_next      = halted_reg | set_misalign;

    if (redirect_i) begin
      // Flush everything younger than the branch; the pending response dies here.
      pc_next         = target_pc;
      out_valid_next  = 1'b0;
      skid_valid_next = 1'b0;
    end else begin
      if (req) begin
        pc_next = pc_reg + AWIDTH'(4);
      end
      if (out_free) begin
        if (resp_valid) begin
          if (skid_valid_reg) begin
            out_valid_next  = 1'b1;
            out_insn_next   = skid_insn_reg;
            out_pc_next     = skid_pc_reg;
            skid_valid_next = 1'b1;
            skid_insn_next  = imem_rdata_i;
            skid_pc_next    = inflight_pc_reg;
          end else begin
            out_valid_next = 1'b1;
            out_insn_next  = imem_rdata_i;
            out_pc_next    = inflight_pc_reg;
          end
        end else if (skid_valid_reg) begin
          out_valid_next  = 1'b1;
          out_insn_next   = skid_insn_reg;
          out_pc_next     = skid_pc_reg;
          skid_valid_next = 1'b0;
        end else begin
          out_valid_next = 1'b0;
        end
      end else if (resp_valid) begin
        // Output is held by decode; park the arriving word.
        skid_valid_next = 1'b1;
        skid_insn_next  = imem_rdata_i;
        skid_pc_next    = inflight_pc_reg;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg          <= BASEADDR;
      out_valid_reg   <= 1'b0;
      out_insn_reg    <= NOP_INSN;
      out_pc_reg      <= BASEADDR;
      skid_valid_reg  <= 1'b0;
      skid_insn_reg   <= NOP_INSN;
      skid_pc_reg     <= BASEADDR;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= BASEADDR;
      halted_reg      <= 1'b0;
    end else begin
      pc_reg          <= pc_next;
      out_valid_reg   <= out_valid_next;
      out_insn_reg    <= out_insn_next;
      out_pc_reg      <= out_pc_next;
      skid_valid_reg  <= skid_valid_next;
      skid_insn_reg   <= skid_insn_next;
      skid_pc_reg     <= skid_pc_next;
      inflight_reg    <= inflight_next;
      inflight_pc_reg <= inflight_pc_next;
      halted_reg      <= halted_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the expected instruction stream is the
// program-order address sequence, restarted on every redirect or reset.
module tb_fetch_stage;

  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o;
  logic [31:0] insn_o;
  logic [31:0] pc_o;
  logic        misalign_o;

  int checks = 0;
  int passes = 0;
  int pops   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_next;

  logic        prev_redirect = 1'b0;
  logic        prev_hold     = 1'b0;
  logic [31:0] prev_pc, prev_insn;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .valid_o(valid_o), .insn_o(insn_o), .pc_o(pc_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Memory: word valid one cycle after the request; junk otherwise.
  always @(posedge clk) begin
    if (imem_req_o) imem_rdata_i <= mem_word(imem_addr_o);
    else            imem_rdata_i <= $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  task automatic top_up();
    while (exp_q.size() < 16) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 32'd4;
    end
  endtask

  task automatic restart_stream(input logic [31:0] start);
    exp_q.delete();
    exp_next = start;
    top_up();
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    top_up();
  endtask

  task automatic do_redirect(input logic [31:0] target, input logic expect_target);
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = target;
    if (expect_target) restart_stream({target[31:2], 2'b00});
    else exp_q.delete();
    step();
    redirect_i = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (valid_o) seen = 1'b1;
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  // Monitor: pops the expected stream whenever decode consumes an instruction.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_redirect) chk("flush_after_redirect", {31'd0, valid_o}, 32'd0);
      if (prev_hold) begin
        chk("hold_valid", {31'd0, valid_o}, 32'd1);
        chk("hold_pc", pc_o, prev_pc);
        chk("hold_insn", insn_o, prev_insn);
      end
      if (valid_o && !stall_i && !redirect_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_insn_pc", pc_o, 32'hFFFF_FFFF);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          pops++;
          chk("stream_pc", pc_o, e);
          chk("stream_insn", insn_o, mem_word(e));
        end
      end
    end
    prev_redirect = redirect_i && !rst;
    prev_hold     = valid_o && stall_i && !redirect_i && !rst;
    prev_pc       = pc_o;
    prev_insn     = insn_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
    exp_next = BASE;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {31'd0, valid_o}, 32'd0);
    chk("reset_insn", insn_o, NOP);
    chk("reset_pc", pc_o, BASE);
    chk("reset_misalign", {31'd0, misalign_o}, 32'd0);
    chk("reset_req", {31'd0, imem_req_o}, 32'd0);

    // Release: first request from BASE immediately, first output two cycles later.
    @(posedge clk); #2;
    rst = 1'b0;
    restart_stream(BASE);
    #1;
    chk("first_req", {31'd0, imem_req_o}, 32'd1);
    chk("first_addr", imem_addr_o, BASE);
    @(negedge clk); chk("startup_c0_valid", {31'd0, valid_o}, 32'd0);
    @(negedge clk); chk("startup_c1_valid", {31'd0, valid_o}, 32'd0);
    @(negedge clk); chk("startup_c2_valid", {31'd0, valid_o}, 32'd1);
    repeat (8) step();

    // Three-cycle stall from steady state: buffers fill, requests stop.
    stall_i = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("stall_no_req", {31'd0, imem_req_o}, 32'd0);
    step();
    stall_i = 1'b0;
    repeat (6) step();

    // Redirect with a fetch in flight.
    do_redirect(32'h0100_0100, 1'b1);
    wait_valid("redirect_target_valid");
    chk("redirect_target_pc", pc_o, 32'h0100_0100);
    repeat (4) step();

    // Redirect and stall together: redirect wins.
    stall_i = 1'b1;
    step();
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0100_0800;
    restart_stream(32'h0100_0800);
    step();
    redirect_i = 1'b0;
    stall_i    = 1'b0;
    wait_valid("redirect_over_stall_valid");
    chk("redirect_over_stall_pc", pc_o, 32'h0100_0800);

    // PC wraparound at the top of the address space.
    do_redirect(32'hFFFF_FFF8, 1'b1);
    repeat (8) step();

    // Randomized stalls and redirects.
    for (int i = 0; i < 600; i++) begin
      step();
      stall_i = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 4) begin
        redirect_i    = 1'b1;
        redirect_pc_i = BASE + ($urandom_range(0, 1023) << 2);
        restart_stream(redirect_pc_i);
      end else begin
        redirect_i = 1'b0;
      end
    end
    step();
    redirect_i = 1'b0;
    stall_i    = 1'b0;
    repeat (4) step();

    // Asynchronous reset with the skid buffer full.
    stall_i = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    #1;
    chk("midreset_valid", {31'd0, valid_o}, 32'd0);
    chk("midreset_insn", insn_o, NOP);
    chk("midreset_pc", pc_o, BASE);
    chk("midreset_req", {31'd0, imem_req_o}, 32'd0);
    step();
    rst     = 1'b0;
    stall_i = 1'b0;
    restart_stream(BASE);
    #1;
    chk("refetch_addr", imem_addr_o, BASE);
    wait_valid("refetch_valid");
    chk("refetch_pc", pc_o, BASE);
    repeat (4) step();

    // Misaligned redirect.
`ifdef FETCH_MISALIGN_TRAP_EN
    do_redirect(32'h0100_0102, 1'b0);
    #1;
    chk("misalign_flag", {31'd0, misalign_o}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("misalign_no_req", {31'd0, imem_req_o}, 32'd0);
    end
`else
    do_redirect(32'h0100_0102, 1'b1);
    wait_valid("misalign_ignored_valid");
    chk("misalign_ignored_pc", pc_o, 32'h0100_0100);
    chk("misalign_flag_zero", {31'd0, misalign_o}, 32'd0);
    repeat (4) step();
`endif

    chk("stream_progress", {31'd0, pops > 300}, 32'd1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
